// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the unified-memory access controller: FSM states,
// RISC-V load/store width codes and the reset instruction.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/mem_align_check.sv
// Flags a halfword access on an odd address or a word access not on a
// 4-byte boundary; byte accesses and unknown width codes never trap.
module mem_align_check
    import mem_ctrl_pkg::*;
(
    input  logic [2:0] fun3,
    input  logic [1:0] addr,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (fun3)
            F3_H, F3_HU: misaligned = addr[0];
            F3_W:        misaligned = |addr;
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Time-multiplexes the single-ported memory between instruction fetch and the
// MEM-stage load/store, alternating FETCH and DATA cycles until a halt.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_fun3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              halt_req,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_fun3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       load_data,
    output logic              stage_en,
    output logic              misalign,
    output logic              halted
);

    state_t state, state_nxt;
    logic   addr_misaligned;
    logic   unused_addr_bits;

    assign unused_addr_bits = ^{pc[31:ADDR_W+2], pc[1:0], ex_addr[31:ADDR_W]};

    mem_align_check u_align (
        .fun3       (ex_fun3),
        .addr       (ex_addr[1:0]),
        .misaligned (addr_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_fun3  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        stage_en  = 1'b0;
        misalign  = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                state_nxt = DATA;
                mem_addr  = pc[ADDR_W+1:2];
            end
            DATA: begin
                state_nxt = halt_req ? HALT : FETCH;
                mem_fun3  = ex_fun3;
                mem_addr  = ex_addr[ADDR_W-1:0];
                mem_wdata = ex_wdata;
                misalign  = (ex_mem_read | ex_mem_write) & addr_misaligned;
                // A simultaneous read and write is resolved in favour of the store.
                mem_write = ex_mem_write & ~misalign;
                mem_read  = ex_mem_read & ~ex_mem_write & ~misalign;
                stage_en  = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
        // Reset must never let a pending store reach the memory.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_fun3  = '0;
            mem_addr  = '0;
            mem_wdata = '0;
            stage_en  = 1'b0;
            misalign  = 1'b0;
            halted    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                instr <= NOP_INSTR;
        else if (state == FETCH) instr <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst)               load_data <= '0;
        else if (state == DATA) load_data <= mem_read ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a behavioural memory plus a
// cycle-level reference model of the FETCH/DATA/HALT schedule.
module tb_mem_access_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ex_mem_read, ex_mem_write;
    logic [2:0]  ex_fun3;
    logic [31:0] ex_addr, ex_wdata;
    logic        halt_req;
    logic        mem_read, mem_write;
    logic [2:0]  mem_fun3;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] instr, load_data;
    logic        stage_en, misalign, halted;

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    int          rd_a;

    int          n_tests = 0;
    int          n_fail  = 0;

    bit          m_data, m_halted;
    logic [31:0] m_instr, m_load;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(6), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_fun3(ex_fun3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .halt_req(halt_req),
        .mem_read(mem_read), .mem_write(mem_write), .mem_fun3(mem_fun3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .instr(instr), .load_data(load_data), .stage_en(stage_en),
        .misalign(misalign), .halted(halted)
    );

    // Memory block: combinational read, instruction words live at 512 + 4*index.
    always_comb begin
        rd_a      = int'(mem_addr);
        mem_rdata = '0;
        if (mem_read) begin
            case (mem_fun3)
                3'b000:  mem_rdata = {{24{mem[rd_a][7]}}, mem[rd_a]};
                3'b100:  mem_rdata = {24'h0, mem[rd_a]};
                3'b001:  mem_rdata = {{16{mem[rd_a+1][7]}}, mem[rd_a+1], mem[rd_a]};
                3'b101:  mem_rdata = {16'h0, mem[rd_a+1], mem[rd_a]};
                3'b010:  mem_rdata = {mem[rd_a+3], mem[rd_a+2], mem[rd_a+1], mem[rd_a]};
                default: mem_rdata = '0;
            endcase
        end else begin
            rd_a      = 512 + 4 * int'(mem_addr);
            mem_rdata = {mem[rd_a+3], mem[rd_a+2], mem[rd_a+1], mem[rd_a]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_word(input int b);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] mem_word(input int b);
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    function automatic int access_size(input logic [2:0] f3);
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        if (f3 == 3'b010) return 4;
        return 1;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a % 32'd64) % access_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        int v;
        case (f3)
            3'b000: begin v = int'(ref_mem[a]); if (v >= 128) v -= 256; return 32'(v); end
            3'b100: return 32'(int'(ref_mem[a]));
            3'b001: begin
                v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
                if (v >= 32768) v -= 65536;
                return 32'(v);
            end
            3'b101: return 32'(int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]));
            3'b010: return ref_word(a);
            default: return 32'h0;
        endcase
    endfunction

    task automatic store(input bit to_ref, input logic [2:0] f3, input int a, input logic [31:0] d);
        for (int k = 0; k < access_size(f3); k++) begin
            if (to_ref) ref_mem[a+k] = d[8*k +: 8];
            else        mem[a+k]     = d[8*k +: 8];
        end
    endtask

    task automatic step(input logic r, input logic [31:0] p, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic h);
        logic       e_rd, e_wr, e_se, e_mis, e_hlt;
        logic [2:0] e_f3, w_f3;
        logic [5:0] e_addr, w_a;
        logic [31:0] e_wd, w_d;
        logic       w_en;
        int         da;
        @(negedge clk);
        rst = r; pc = p; ex_mem_read = rd; ex_mem_write = wr;
        ex_fun3 = f3; ex_addr = a; ex_wdata = wd; halt_req = h;
        #1;
        {e_rd, e_wr, e_se, e_mis, e_hlt} = '0;
        e_f3 = '0; e_addr = '0; e_wd = '0;
        da = int'(a % 32'd64);
        if (!r) begin
            if (m_halted) e_hlt = 1'b1;
            else if (!m_data) e_addr = 6'((p / 4) % 64);
            else begin
                e_mis  = (rd || wr) && is_mis(f3, a);
                e_wr   = wr && !e_mis;
                e_rd   = rd && !wr && !e_mis;
                e_f3   = f3; e_addr = 6'(da); e_wd = wd; e_se = 1'b1;
            end
        end
        check("mem_read",  32'(mem_read),  32'(e_rd));
        check("mem_write", 32'(mem_write), 32'(e_wr));
        check("mem_fun3",  32'(mem_fun3),  32'(e_f3));
        check("mem_addr",  32'(mem_addr),  32'(e_addr));
        check("mem_wdata", mem_wdata, e_wd);
        check("stage_en",  32'(stage_en),  32'(e_se));
        check("misalign",  32'(misalign),  32'(e_mis));
        check("halted",    32'(halted),    32'(e_hlt));
        check("instr",     instr,     m_instr);
        check("load_data", load_data, m_load);
        w_en = mem_write; w_f3 = mem_fun3; w_a = mem_addr; w_d = mem_wdata;
        @(posedge clk);
        #1;
        if (w_en) store(1'b0, w_f3, int'(w_a), w_d);
        if (r) begin
            m_data = 1'b0; m_halted = 1'b0; m_instr = NOP; m_load = '0;
        end else if (!m_halted) begin
            if (!m_data) begin
                m_instr = ref_word(512 + 4 * int'(e_addr));
                m_data  = 1'b1;
            end else begin
                m_load = e_rd ? ref_load(f3, da) : 32'h0;
                if (e_wr) store(1'b1, f3, da, wd);
                m_halted = h;
                m_data   = 1'b0;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, $urandom, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic data_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic h);
        if (!m_data) idle();
        step(1'b0, $urandom, rd, wr, f3, a, wd, h);
    endtask

    initial begin
        logic [31:0] saved;
        int          nbad;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[1] = 8'h83; ref_mem[1] = 8'h83;
        rst = 1'b1; pc = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_fun3 = '0; ex_addr = '0; ex_wdata = '0; halt_req = 1'b0;
        m_data = 1'b0; m_halted = 1'b0; m_instr = NOP; m_load = '0;
        repeat (2) @(posedge clk);

        // Reset and boot fetch from pc=0.
        step(1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        check("rst_instr", instr, NOP);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        check("boot_instr", instr, ref_word(512));
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);

        // Signed and unsigned byte loads.
        data_op(1'b1, 1'b0, 3'b000, 32'd1, 32'h0, 1'b0);
        check("lb", load_data, 32'hFFFF_FF83);
        data_op(1'b1, 1'b0, 3'b100, 32'd1, 32'h0, 1'b0);
        check("lbu", load_data, 32'h0000_0083);

        // Store then load back.
        data_op(1'b0, 1'b1, 3'b010, 32'd8, 32'hDEAD_BEEF, 1'b0);
        data_op(1'b1, 1'b0, 3'b010, 32'd8, 32'h0, 1'b0);
        check("lw_after_sw", load_data, 32'hDEAD_BEEF);

        // Misaligned accesses are suppressed.
        saved = mem_word(0);
        data_op(1'b1, 1'b0, 3'b010, 32'd6, 32'h0, 1'b0);
        check("lw_mis_load", load_data, 32'h0);
        data_op(1'b0, 1'b1, 3'b001, 32'd3, 32'h1234_5678, 1'b0);
        check("sh_mis_mem", mem_word(0), saved);

        // Reset during a DATA-cycle store, then fetch with a wrapping pc.
        saved = mem_word(4);
        if (!m_data) idle();
        step(1'b1, 32'h0, 1'b0, 1'b1, 3'b010, 32'd4, 32'hCAFE_F00D, 1'b0);
        check("rst_store_mem", mem_word(4), saved);
        step(1'b0, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        check("wrap_instr", instr, ref_word(512));

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 49) == 0), $urandom, 1'($urandom), 1'($urandom),
                 3'($urandom), $urandom, $urandom, 1'b0);
        end

        // Halt, stay frozen while requests keep arriving, then reset out.
        data_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, $urandom, 1'($urandom), 1'($urandom), 3'($urandom),
                 $urandom, $urandom, 1'($urandom));
        end
        check("halt_held", 32'(halted), 32'd1);
        step(1'b1, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) idle();
        check("halt_cleared", 32'(halted), 32'd0);

        nbad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
        check("mem_image", 32'(nbad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
